run_length_hist: RTL

//  Downstream statistics stage for the 23-bit LFSR. It consumes one bit per shift (Q_out tap) and bins the lengths of

---
 rtl/lfsr_pkg.sv | 22 ++
 rtl/run_hist_bank.sv | 39 +++
 rtl/run_length_hist.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// Definitions shared by the LFSR, its bit counter and the run-length histogram.
package lfsr_pkg;

  localparam int unsigned LFSR_W = 23;
  localparam int unsigned CNT_W  = 24;

  typedef enum logic [0:0] {
    S_IDLE,
    S_RUN
  } run_state_e;

  // Minimum bit count able to index v distinct values.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/run_hist_bank.sv
// One polarity's working histogram: saturating single-bin increment, clear, and a
// copy-out view that already includes the increment applied this cycle.
module run_hist_bank
  import lfsr_pkg::*;
#(
  parameter int unsigned MAX_RUN = 24,
  parameter int unsigned CNT_W   = lfsr_pkg::CNT_W,
  localparam int unsigned IDX_W  = clog2(MAX_RUN)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             inc_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] bins_o [MAX_RUN]
);

  logic [CNT_W-1:0] bins_q [MAX_RUN];

  always_comb begin
    for (int unsigned k = 0; k < MAX_RUN; k++) begin
      bins_o[k] = bins_q[k];
      if (inc_i && (32'(idx_i) == k) && (bins_q[k] != '1)) begin
        bins_o[k] = bins_q[k] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int unsigned k = 0; k < MAX_RUN; k++) begin
      if (reset_i || clr_i) begin
        bins_q[k] <= '0;
      end else begin
        bins_q[k] <= bins_o[k];
      end
    end
  end

endmodule

// File: rtl/run_length_hist.sv
// Bins zero/one run lengths of the LFSR bit stream; each max_tick freezes the working
// histograms into a readable snapshot bank and clears them.
module run_length_hist
  import lfsr_pkg::*;
#(
  parameter int unsigned MAX_RUN = 24,
  parameter int unsigned CNT_W   = lfsr_pkg::CNT_W,
  parameter int unsigned ADDR_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sh_en,
  input  logic              bit_in,
  input  logic              max_tick,
  input  logic              rd_sel,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [CNT_W-1:0]  rd_data,
  output logic [CNT_W-1:0]  run_total,
  output logic              stats_valid,
  output logic              snap_tick
);

  localparam int unsigned LEN_W = clog2(MAX_RUN + 1);
  localparam int unsigned IDX_W = clog2(MAX_RUN);

  run_state_e       state_q, state_d;
  logic             prev_q, prev_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] wtotal_q, wtotal_nxt;
  logic [CNT_W:0]   wsum;
  logic [CNT_W-1:0] snap_q [2][MAX_RUN];
  logic [CNT_W-1:0] run_total_q;
  logic [CNT_W-1:0] rd_data_q, rd_mux;
  logic             stats_valid_q, snap_tick_q;

  logic             close1, close2;
  logic [LEN_W-1:0] len1_m1, len2_m1;
  logic [IDX_W-1:0] idx1, idx2;
  logic             inc_zero, inc_one;
  logic [IDX_W-1:0] idx_zero, idx_one;
  logic [CNT_W-1:0] bins_zero [MAX_RUN];
  logic [CNT_W-1:0] bins_one  [MAX_RUN];

  // close1: run ended by a polarity change; close2: open run ended by max_tick.
  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    len_d   = len_q;
    close1  = 1'b0;
    close2  = 1'b0;
    if (sh_en) begin
      if (state_q == S_IDLE) begin
        prev_d  = bit_in;
        len_d   = LEN_W'(1);
        state_d = S_RUN;
      end else if (bit_in == prev_q) begin
        if (len_q < LEN_W'(MAX_RUN)) len_d = len_q + 1'b1;
      end else begin
        close1 = 1'b1;
        prev_d = bit_in;
        len_d  = LEN_W'(1);
      end
    end
    if (max_tick) begin
      close2  = sh_en || (state_q == S_RUN);
      state_d = S_IDLE;
    end
  end

  assign len1_m1 = len_q - 1'b1;
  assign len2_m1 = len_d - 1'b1;
  assign idx1    = len1_m1[IDX_W-1:0];
  assign idx2    = len2_m1[IDX_W-1:0];

  // A double closure always has opposite polarities, so each bank sees at most one.
  always_comb begin
    inc_zero = (close1 && !prev_q) || (close2 && !prev_d);
    inc_one  = (close1 && prev_q) || (close2 && prev_d);
    idx_zero = (close1 && !prev_q) ? idx1 : idx2;
    idx_one  = (close1 && prev_q) ? idx1 : idx2;
  end

  always_comb begin
    wsum       = {1'b0, wtotal_q} + (CNT_W + 1)'(close1) + (CNT_W + 1)'(close2);
    wtotal_nxt = wsum[CNT_W] ? '1 : wsum[CNT_W-1:0];
  end

  always_comb begin
    rd_mux = '0;
    for (int unsigned k = 0; k < MAX_RUN; k++) begin
      if (32'(rd_addr) == k) rd_mux = rd_sel ? snap_q[1][k] : snap_q[0][k];
    end
  end

  run_hist_bank #(
    .MAX_RUN (MAX_RUN),
    .CNT_W   (CNT_W)
  ) u_bank_zero (
    .clk_i   (clk),
    .reset_i (reset),
    .inc_i   (inc_zero),
    .idx_i   (idx_zero),
    .clr_i   (max_tick),
    .bins_o  (bins_zero)
  );

  run_hist_bank #(
    .MAX_RUN (MAX_RUN),
    .CNT_W   (CNT_W)
  ) u_bank_one (
    .clk_i   (clk),
    .reset_i (reset),
    .inc_i   (inc_one),
    .idx_i   (idx_one),
    .clr_i   (max_tick),
    .bins_o  (bins_one)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      prev_q        <= 1'b0;
      len_q         <= '0;
      wtotal_q      <= '0;
      run_total_q   <= '0;
      rd_data_q     <= '0;
      stats_valid_q <= 1'b0;
      snap_tick_q   <= 1'b0;
      for (int unsigned k = 0; k < MAX_RUN; k++) begin
        snap_q[0][k] <= '0;
        snap_q[1][k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      len_q       <= len_d;
      snap_tick_q <= max_tick;
      rd_data_q   <= rd_mux;
      if (max_tick) begin
        wtotal_q      <= '0;
        run_total_q   <= wtotal_nxt;
        stats_valid_q <= 1'b1;
        for (int unsigned k = 0; k < MAX_RUN; k++) begin
          snap_q[0][k] <= bins_zero[k];
          snap_q[1][k] <= bins_one[k];
        end
      end else begin
        wtotal_q <= wtotal_nxt;
      end
    end
  end

  assign rd_data     = rd_data_q;
  assign run_total   = run_total_q;
  assign stats_valid = stats_valid_q;
  assign snap_tick   = snap_tick_q;

endmodule
